// File: rtl/matrix_mult_seq_lanes_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_mult_seq_lanes_if                                   |
// | Description : start/busy/done handshake and flattened row-major matrix   |
// |               buses for the sequential lane-based matrix multiplier.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface matrix_mult_seq_lanes_if #(
  parameter int MAX_SIZE   = 10,
  parameter int DATA_WIDTH = 32
);
  logic                                   start;
  logic [31:0]                            rows_a;
  logic [31:0]                            inner;
  logic [31:0]                            cols_b;
  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] A;
  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] B;
  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] C;
  logic                                   busy;
  logic                                   done;
  logic                                   overflow;
  logic                                   err;

  // Requester side: issues operands and the start request.
  modport master (
    output start, rows_a, inner, cols_b, A, B,
    input  C, busy, done, overflow, err
  );

  // Multiplier side.
  modport slave (
    input  start, rows_a, inner, cols_b, A, B,
    output C, busy, done, overflow, err
  );
endinterface
`default_nettype wire

// File: rtl/matrix_mult_seq_lanes.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_mult_seq_lanes                                      |
// | Description : Sequential C = A*B for rectangular operands up to          |
// |               MAX_SIZE per dimension, on LANES time-shared MAC lanes.    |
// |               Each lane owns one column of C inside a column group; one  |
// |               inner index k is consumed per cycle.                       |
// | Options     : MATMUL_SIGNED_EN - two's-complement elements when defined, |
// |               unsigned elements otherwise.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module matrix_mult_seq_lanes #(
  parameter int MAX_SIZE   = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_mult_seq_lanes_if.slave bus
);

`ifdef MATMUL_SIGNED_EN
  localparam bit c_SIGNED = 1'b1;
`else
  localparam bit c_SIGNED = 1'b0;
`endif

  localparam int c_NBITS = MAX_SIZE*MAX_SIZE*DATA_WIDTH;
  localparam int c_BW    = $clog2(c_NBITS);
  localparam int c_IW    = $clog2(MAX_SIZE+1);
  localparam int c_PW    = 2*DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_NBITS-1:0]   r_a;
  logic [c_NBITS-1:0]   r_b;
  logic [c_NBITS-1:0]   r_c;
  logic [c_IW-1:0]      r_ilast;
  logic [c_IW-1:0]      r_klast;
  logic [c_IW-1:0]      r_glast;
  logic [c_IW-1:0]      r_cols;
  logic [c_IW-1:0]      r_i;
  logic [c_IW-1:0]      r_k;
  logic [c_IW-1:0]      r_g;
  logic [ACC_WIDTH-1:0] r_acc [LANES];
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ovf;
  logic                 r_err;

  logic                  w_dim_bad;
  logic                  w_k_last;
  logic                  w_g_last;
  logic                  w_i_last;
  logic [c_BW-1:0]       w_a_bit;
  logic [DATA_WIDTH-1:0] w_a_el;
  logic [c_PW-1:0]       w_ax;
  logic                  w_act   [LANES];
  logic [c_BW-1:0]       w_b_bit [LANES];
  logic [c_BW-1:0]       w_c_bit [LANES];
  logic [DATA_WIDTH-1:0] w_b_el  [LANES];
  logic [c_PW-1:0]       w_bx    [LANES];
  logic [c_PW-1:0]       w_prod  [LANES];
  logic [ACC_WIDTH-1:0]  w_sum   [LANES];
  logic                  w_fit   [LANES];

  // Dimension check on the live request; a zero or oversized dimension never computes.
  assign w_dim_bad = (bus.rows_a == 32'd0) || (bus.rows_a > 32'(MAX_SIZE)) ||
                     (bus.inner  == 32'd0) || (bus.inner  > 32'(MAX_SIZE)) ||
                     (bus.cols_b == 32'd0) || (bus.cols_b > 32'(MAX_SIZE));

  assign w_k_last = (r_k == r_klast);
  assign w_g_last = (r_g == r_glast);
  assign w_i_last = (r_i == r_ilast);

  // Operand fetch, exact product, running sum and fit test for every lane.
  always_comb begin
    w_a_bit = c_BW'((int'(r_i)*MAX_SIZE + int'(r_k)) * DATA_WIDTH);
    w_a_el  = r_a[w_a_bit +: DATA_WIDTH];
    w_ax    = {{DATA_WIDTH{c_SIGNED & w_a_el[DATA_WIDTH-1]}}, w_a_el};
    for (int l = 0; l < LANES; l++) begin
      // Lanes past the last column sit idle; their indices are parked at 0.
      w_act[l]   = (int'(r_g)*LANES + l) < int'(r_cols);
      w_b_bit[l] = w_act[l] ? c_BW'((int'(r_k)*MAX_SIZE + int'(r_g)*LANES + l) * DATA_WIDTH) : '0;
      w_c_bit[l] = w_act[l] ? c_BW'((int'(r_i)*MAX_SIZE + int'(r_g)*LANES + l) * DATA_WIDTH) : '0;
      w_b_el[l]  = r_b[w_b_bit[l] +: DATA_WIDTH];
      w_bx[l]    = {{DATA_WIDTH{c_SIGNED & w_b_el[l][DATA_WIDTH-1]}}, w_b_el[l]};
      // Low 2*DATA_WIDTH bits of the extended product are exact in both modes.
      w_prod[l]  = w_ax * w_bx[l];
      w_sum[l]   = r_acc[l] + {{(ACC_WIDTH-c_PW){c_SIGNED & w_prod[l][c_PW-1]}}, w_prod[l]};
      w_fit[l]   = c_SIGNED ? ((&w_sum[l][ACC_WIDTH-1:DATA_WIDTH-1]) |
                               ~(|w_sum[l][ACC_WIDTH-1:DATA_WIDTH-1]))
                            : ~(|w_sum[l][ACC_WIDTH-1:DATA_WIDTH]);
    end
  end

  // Control FSM, operand capture, lane accumulation and result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_ilast <= '0;
      r_klast <= '0;
      r_glast <= '0;
      r_cols  <= '0;
      r_i     <= '0;
      r_k     <= '0;
      r_g     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_c     <= '0;
            r_ovf   <= 1'b0;
            r_i     <= '0;
            r_k     <= '0;
            r_g     <= '0;
            // Stored as last-index values; meaningless but harmless on the error path.
            r_ilast <= c_IW'(bus.rows_a - 32'd1);
            r_klast <= c_IW'(bus.inner - 32'd1);
            r_glast <= c_IW'((bus.cols_b - 32'd1) / 32'(LANES));
            r_cols  <= c_IW'(bus.cols_b);
            for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
            if (w_dim_bad) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          for (int l = 0; l < LANES; l++) begin
            if (w_act[l]) begin
              if (w_k_last) begin
                r_c[w_c_bit[l] +: DATA_WIDTH] <= w_sum[l][DATA_WIDTH-1:0];
                if (!w_fit[l]) r_ovf <= 1'b1;
                r_acc[l] <= '0;
              end else begin
                r_acc[l] <= w_sum[l];
              end
            end
          end
          // k innermost, then column group, then row.
          if (w_k_last) begin
            r_k <= '0;
            if (w_g_last) begin
              r_g <= '0;
              if (w_i_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_g <= r_g + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.C        = r_c;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_seq_lanes.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_matrix_mult_seq_lanes                                   |
// | Description : Self-checking bench: table of operations with a reference  |
// |               model feeding a scoreboard, plus busy-start and mid-run    |
// |               reset sequences.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_matrix_mult_seq_lanes;
  localparam int MAX_SIZE   = 10;
  localparam int DATA_WIDTH = 32;
  localparam int LANES      = 2;
  localparam int ACC_WIDTH  = 2*DATA_WIDTH+8;
  localparam int NBITS      = MAX_SIZE*MAX_SIZE*DATA_WIDTH;
  localparam int NVEC       = 12;

  localparam int M_CONST = 0;
  localparam int M_RAMP  = 1;
  localparam int M_IDENT = 2;
  localparam int M_RAND  = 3;
  localparam int M_SMALL = 4;

  typedef struct {
    string       name;
    int          rows;
    int          inner;
    int          cols;
    int          a_mode;
    logic [31:0] a_val;
    int          b_mode;
    logic [31:0] b_val;
    int          exp_t;
    bit          exp_err;
  } vec_t;

  typedef struct {
    string            name;
    logic [NBITS-1:0] c;
    bit               ovf;
    bit               err;
    int               lat;
    int               start_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_mult_seq_lanes_if #(.MAX_SIZE(MAX_SIZE), .DATA_WIDTH(DATA_WIDTH)) bus ();

  matrix_mult_seq_lanes #(
    .MAX_SIZE  (MAX_SIZE),
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (LANES),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  vec_t        vecs [NVEC];
  sb_t         sbq [$];
  sb_t         m_e;
  logic [31:0] am [MAX_SIZE][MAX_SIZE];
  logic [31:0] bm [MAX_SIZE][MAX_SIZE];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          busy_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mkv(input string nm, input int r, input int n, input int c,
                               input int am_, input logic [31:0] av,
                               input int bm_, input logic [31:0] bv,
                               input int t, input bit e);
    vec_t v;
    v.name = nm; v.rows = r; v.inner = n; v.cols = c;
    v.a_mode = am_; v.a_val = av; v.b_mode = bm_; v.b_val = bv;
    v.exp_t = t; v.exp_err = e;
    return v;
  endfunction

  function automatic logic [31:0] gen(input int mode, input logic [31:0] val,
                                      input int r, input int c, input int ncol);
    case (mode)
      M_CONST: return val;
      M_RAMP:  return 32'(r*ncol + c + 1);
      M_IDENT: return (r == c) ? 32'd1 : 32'd0;
      M_RAND:  return $urandom;
      default: return 32'($urandom_range(0, 1000));
    endcase
  endfunction

  function automatic logic [31:0] el(input logic [NBITS-1:0] v, input int idx);
    return 32'(v >> (idx*DATA_WIDTH));
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_c(input string nm, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
    int bad;
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      bad = 0;
      for (int i = MAX_SIZE*MAX_SIZE-1; i >= 0; i--)
        if (el(act, i) !== el(exp, i)) bad = i;
      $display("FAIL %s: C[%0d][%0d] got %h, required %h", nm, bad / MAX_SIZE, bad % MAX_SIZE,
               el(act, bad), el(exp, bad));
    end
  endtask

  // Reference product over the generated operand matrices.
  task automatic model(input vec_t v, output logic [NBITS-1:0] c, output bit ovf);
`ifdef MATMUL_SIGNED_EN
    logic signed [ACC_WIDTH-1:0] s, ea, eb;
`else
    logic [ACC_WIDTH-1:0] s, ea, eb;
`endif
    c = '0;
    ovf = 1'b0;
    if (v.exp_err) return;
    for (int i = 0; i < v.rows; i++) begin
      for (int j = 0; j < v.cols; j++) begin
        s = '0;
        for (int k = 0; k < v.inner; k++) begin
`ifdef MATMUL_SIGNED_EN
          ea = $signed(am[i][k]);
          eb = $signed(bm[k][j]);
`else
          ea = am[i][k];
          eb = bm[k][j];
`endif
          s = s + ea * eb;
        end
`ifdef MATMUL_SIGNED_EN
        if (s > 72'sd2147483647 || s < -72'sd2147483648) ovf = 1'b1;
`else
        if (s > 72'hFFFF_FFFF) ovf = 1'b1;
`endif
        c = c | (NBITS'(s[31:0]) << ((i*MAX_SIZE + j)*DATA_WIDTH));
      end
    end
  endtask

  task automatic build(input vec_t v);
    bus.A = '0;
    bus.B = '0;
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        am[r][c] = gen(v.a_mode, v.a_val, r, c, v.inner);
        bm[r][c] = gen(v.b_mode, v.b_val, r, c, v.cols);
        bus.A = bus.A | (NBITS'(am[r][c]) << ((r*MAX_SIZE + c)*DATA_WIDTH));
        bus.B = bus.B | (NBITS'(bm[r][c]) << ((r*MAX_SIZE + c)*DATA_WIDTH));
      end
    end
    bus.rows_a = 32'(v.rows);
    bus.inner  = 32'(v.inner);
    bus.cols_b = 32'(v.cols);
  endtask

  // Drive one request and push its expected outcome.
  task automatic issue(input vec_t v, output sb_t e);
    logic [NBITS-1:0] c;
    bit               o;
    @(negedge clk);
    build(v);
    model(v, c, o);
    e.name = v.name;
    e.c    = c;
    e.ovf  = o;
    e.err  = v.exp_err;
    e.lat  = v.exp_t;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.start_cyc = cyc;
    sbq.push_back(e);
  endtask

  // Bounded wait for done, then check the pulse width and that results hold.
  task automatic finish_op(input sb_t e, input int budget);
    bit got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles, required done", e.name, budget);
      sbq.delete();
      return;
    end
    bus.A = {(NBITS/32){32'hDEAD_BEEF}};
    bus.B = {(NBITS/32){32'h1234_5678}};
    @(negedge clk);
    chk({e.name, "_done_pulse"}, longint'(bus.done), 0);
    @(negedge clk);
    chk_c({e.name, "_C_hold"}, bus.C, e.c);
    chk({e.name, "_ovf_hold"}, longint'(bus.overflow), longint'(e.ovf));
    chk({e.name, "_err_hold"}, longint'(bus.err), longint'(e.err));
  endtask

  // Scoreboard consumer: every done pops and checks one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_done: got done=1, required no done (nothing pending)");
        end else begin
          m_e = sbq.pop_front();
          chk({m_e.name, "_latency"}, longint'(cyc - m_e.start_cyc), longint'(m_e.lat));
          chk({m_e.name, "_busy_cycles"}, longint'(busy_cnt), longint'(m_e.lat));
          chk_c({m_e.name, "_C"}, bus.C, m_e.c);
          chk({m_e.name, "_overflow"}, longint'(bus.overflow), longint'(m_e.ovf));
          chk({m_e.name, "_err"}, longint'(bus.err), longint'(m_e.err));
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    sb_t e;
    //                 name          rows inner cols  A mode  A val          B mode   B val  T    err
    vecs[0]  = mkv("identity",     2,  2,   2, M_RAMP,  32'd0,         M_IDENT, 32'd0, 4,   1'b0);
    vecs[1]  = mkv("rect",         3,  2,   5, M_CONST, 32'd2,         M_CONST, 32'd3, 18,  1'b0);
    vecs[2]  = mkv("full_ones",   10, 10,  10, M_CONST, 32'd1,         M_CONST, 32'd1, 500, 1'b0);
    vecs[3]  = mkv("ovf_1x1",      1,  1,   1, M_CONST, 32'h0001_0000, M_CONST, 32'h0001_0000, 1, 1'b0);
    vecs[4]  = mkv("neg1_x5",      1,  1,   1, M_CONST, 32'hFFFF_FFFF, M_CONST, 32'd5, 1,   1'b0);
    vecs[5]  = mkv("inner0",       2,  0,   2, M_CONST, 32'd1,         M_CONST, 32'd1, 0,   1'b1);
    vecs[6]  = mkv("cols11",       2,  2,  11, M_CONST, 32'd1,         M_CONST, 32'd1, 0,   1'b1);
    vecs[7]  = mkv("rows0",        0,  3,   3, M_CONST, 32'd1,         M_CONST, 32'd1, 0,   1'b1);
    vecs[8]  = mkv("rand_3x4x7",   3,  4,   7, M_SMALL, 32'd0,         M_SMALL, 32'd0, 48,  1'b0);
    vecs[9]  = mkv("rand_10x3x1", 10,  3,   1, M_SMALL, 32'd0,         M_SMALL, 32'd0, 30,  1'b0);
    vecs[10] = mkv("rand_wide",    1, 10,  10, M_RAND,  32'd0,         M_RAND,  32'd0, 50,  1'b0);
    vecs[11] = mkv("tail_4x5x9",   4,  5,   9, M_SMALL, 32'd0,         M_SMALL, 32'd0, 100, 1'b0);

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.rows_a = '0;
    bus.inner  = '0;
    bus.cols_b = '0;
    bus.A      = '0;
    bus.B      = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", longint'(bus.busy), 0);
    chk("reset_done", longint'(bus.done), 0);
    chk("reset_overflow", longint'(bus.overflow), 0);
    chk("reset_err", longint'(bus.err), 0);
    chk_c("reset_C", bus.C, '0);
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      issue(vecs[v], e);
      finish_op(e, vecs[v].exp_t + 20);
    end

    // A second start while computing is dropped; the first result must stand.
    issue(vecs[1], e);
    repeat (3) @(negedge clk);
    bus.A = {(NBITS/32){32'd7}};
    bus.B = {(NBITS/32){32'd7}};
    bus.start = 1'b1;
    chk("busy_during_restart", longint'(bus.busy), 1);
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    finish_op(e, vecs[1].exp_t + 20);

    // Reset in the middle of an operation abandons it and clears everything.
    issue(vecs[10], e);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_busy", longint'(bus.busy), 0);
    chk("midreset_done", longint'(bus.done), 0);
    chk("midreset_overflow", longint'(bus.overflow), 0);
    chk("midreset_err", longint'(bus.err), 0);
    chk_c("midreset_C", bus.C, '0);
    sbq.delete();
    busy_cnt = 0;
    rst = 1'b0;
    issue(vecs[0], e);
    finish_op(e, vecs[0].exp_t + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
